// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and width helpers for the memory port arbiter.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration (owner_e).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // Last transaction owner, used by round-robin arbitration
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Beat index width: clog2 of the line length, never below one bit
  function automatic int unsigned beat_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned BEAT_W         = beat_w(LINE_WORDS_DEF);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port.
// master: the arbiter. slave: caches plus memory model.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  localparam int unsigned BW = beat_w(LINE_WORDS);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_done;

  logic [BW-1:0]     beat_idx;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_valid, i_done, d_rdata, d_valid, d_done, beat_idx,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_valid, i_done, d_rdata, d_valid, d_done, beat_idx,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_beat_counter.sv
// mem_beat_counter: beat counter, last-beat flag and base+offset beat address.
module mem_beat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BW         = beat_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  output logic [BW-1:0]     beat,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic [BW-1:0]     cnt;
  logic [ADDR_W-1:0] base_q;

  // Latch the line base on grant; step the beat on each memory ack
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      base_q <= '0;
    end else if (start) begin
      cnt    <= '0;
      base_q <= base;
    end else if (adv) begin
      cnt <= last ? '0 : cnt + BW'(1);
    end
  end

  assign beat = cnt;
  assign last = (cnt == BW'(LINE_WORDS - 1));
  // Word-address offset; sum wraps modulo 2**ADDR_W
  assign addr = base_q + (ADDR_W'(cnt) << 2);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between icache refills and
// dcache refills/writebacks, one LINE_WORDS-beat transaction at a time.
// Build macro MEM_ARB_RR_EN: round-robin instead of fixed dcache priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned BW = beat_w(LINE_WORDS);

  arb_state_e        state;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              i_valid_q, i_done_q, d_valid_q, d_done_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic              pick_d;
  logic              start;
  logic              adv;
  logic [ADDR_W-1:0] grant_addr;
  logic [BW-1:0]     beat;
  logic              last;
  logic [ADDR_W-1:0] beat_addr;

`ifdef MEM_ARB_RR_EN
  owner_e last_owner;
  assign pick_d = bus.d_req && (!bus.i_req || (last_owner == OWN_I));
`else
  assign pick_d = bus.d_req;
`endif

  assign start      = (state == IDLE) && (bus.d_req || bus.i_req);
  assign grant_addr = pick_d ? bus.d_addr : bus.i_addr;
  // mem_req_q is only high in a grant state, so stray acks are dropped here
  assign adv        = mem_req_q && bus.mem_ack;

  mem_beat_counter #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W),
    .BW         (BW)
  ) u_beat (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .adv   (adv),
    .base  (grant_addr),
    .beat  (beat),
    .last  (last),
    .addr  (beat_addr)
  );

  // Arbitration FSM with registered handshake and read-return outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      i_valid_q <= 1'b0;
      i_done_q  <= 1'b0;
      d_valid_q <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner <= OWN_I;
`endif
    end else begin
      i_valid_q <= 1'b0;
      i_done_q  <= 1'b0;
      d_valid_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= pick_d ? GRANT_D : GRANT_I;
            mem_req_q <= 1'b1;
            mem_we_q  <= pick_d && bus.d_we;
`ifdef MEM_ARB_RR_EN
            last_owner <= pick_d ? OWN_D : OWN_I;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          if (adv) begin
            if (!mem_we_q) begin
              if (state == GRANT_I) begin
                i_rdata_q <= bus.mem_rdata;
                i_valid_q <= 1'b1;
              end else begin
                d_rdata_q <= bus.mem_rdata;
                d_valid_q <= 1'b1;
              end
            end
            if (last) begin
              i_done_q  <= (state == GRANT_I);
              d_done_q  <= (state == GRANT_D);
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = beat_addr;
  // Write data tracks beat_idx combinationally; zero outside writebacks
  assign bus.mem_wdata = mem_we_q ? bus.d_wdata : '0;
  assign bus.beat_idx  = beat;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_done    = d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (LINE_WORDS=4).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory model: ack every gap-th cycle of each beat; read data derived from address
  int       gap = 1;
  logic [3:0] ack_cnt;
  logic     stray_ack = 1'b0;

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) ack_cnt <= 4'd0;
    else                             ack_cnt <= ack_cnt + 4'd1;
  end

  assign bus.mem_ack   = (bus.mem_req && (ack_cnt == 4'(gap - 1))) || stray_ack;
  assign bus.mem_rdata = 32'h0000_00A0 + {28'd0, bus.mem_addr[5:2]};
  assign bus.d_wdata   = 32'hD000_0000 + 32'(bus.beat_idx);

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic             set_i;
    logic             set_d;
    logic             d_we;
    logic [31:0]      i_addr;
    logic [31:0]      d_addr;
    int               gap;
    logic             exp_d;
    logic [3:0][31:0] exp_addr;
    logic [3:0][31:0] exp_data;
    int               lat;
  } vec_t;

  function automatic logic [3:0][31:0] l4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Caller is just past a negedge; runs one transaction to its done pulse
  task automatic run_vec(input vec_t v, input string nm);
    int nb = 0;
    int nv = 0;
    bit seen = 0;
    if (v.set_i) begin bus.i_req = 1'b1; bus.i_addr = v.i_addr; end
    if (v.set_d) begin bus.d_req = 1'b1; bus.d_we = v.d_we; bus.d_addr = v.d_addr; end
    gap = v.gap;
    for (int c = 1; c <= 80 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk({nm, "_grant"}, 32'(bus.mem_req), 32'd1);
      chk({nm, "_other_quiet"}, 32'(v.exp_d ? (bus.i_valid | bus.i_done)
                                            : (bus.d_valid | bus.d_done)), 32'd0);
      if (bus.mem_ack && nb < 4) begin
        chk({nm, "_addr"}, bus.mem_addr, v.exp_addr[nb]);
        chk({nm, "_we"}, 32'(bus.mem_we), 32'(v.d_we && v.exp_d));
        chk({nm, "_beat"}, 32'(bus.beat_idx), 32'(nb));
        if (v.d_we && v.exp_d)
          chk({nm, "_wdata"}, bus.mem_wdata, 32'hD000_0000 + 32'(nb));
        nb++;
      end
      if (v.exp_d ? bus.d_valid : bus.i_valid) begin
        if (nv < 4) chk({nm, "_rdata"}, v.exp_d ? bus.d_rdata : bus.i_rdata, v.exp_data[nv]);
        nv++;
      end
      if (v.exp_d ? bus.d_done : bus.i_done) begin
        chk({nm, "_nbeats"}, 32'(nb), 32'd4);
        chk({nm, "_nvalid"}, 32'(nv), (v.d_we && v.exp_d) ? 32'd0 : 32'd4);
        chk({nm, "_latency"}, 32'(c), 32'(v.lat));
        chk({nm, "_req_gap"}, 32'(bus.mem_req), 32'd0);
        if (v.exp_d) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
        else bus.i_req = 1'b0;
        seen = 1;
      end
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got no done expected done within 80 cycles", nm);
    end
  endtask

  vec_t vecs[7];
  vec_t rv;
  int   acks;

  initial begin
    vecs[0] = '{1, 0, 0, 32'h100, 32'h0, 1, 0,
                l4(32'h100, 32'h104, 32'h108, 32'h10C), l4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 5};
    vecs[1] = '{1, 1, 1, 32'h110, 32'h200, 1, 1,
                l4(32'h200, 32'h204, 32'h208, 32'h20C), l4(32'h0, 32'h0, 32'h0, 32'h0), 5};
    vecs[2] = '{0, 0, 0, 32'h110, 32'h0, 1, 0,
                l4(32'h110, 32'h114, 32'h118, 32'h11C), l4(32'hA4, 32'hA5, 32'hA6, 32'hA7), 5};
    vecs[3] = '{0, 1, 0, 32'h0, 32'h300, 3, 1,
                l4(32'h300, 32'h304, 32'h308, 32'h30C), l4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 13};
`ifdef MEM_ARB_RR_EN
    // Previous owner was dcache, so icache goes first
    vecs[4] = '{1, 1, 0, 32'h1A0, 32'h340, 1, 0,
                l4(32'h1A0, 32'h1A4, 32'h1A8, 32'h1AC), l4(32'hA8, 32'hA9, 32'hAA, 32'hAB), 5};
    vecs[5] = '{0, 0, 0, 32'h1A0, 32'h340, 1, 1,
                l4(32'h340, 32'h344, 32'h348, 32'h34C), l4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 5};
`else
    vecs[4] = '{1, 1, 0, 32'h1A0, 32'h340, 1, 1,
                l4(32'h340, 32'h344, 32'h348, 32'h34C), l4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 5};
    vecs[5] = '{0, 0, 0, 32'h1A0, 32'h340, 1, 0,
                l4(32'h1A0, 32'h1A4, 32'h1A8, 32'h1AC), l4(32'hA8, 32'hA9, 32'hAA, 32'hAB), 5};
`endif
    vecs[6] = '{1, 0, 0, 32'hFFFF_FFF8, 32'h0, 1, 0,
                l4(32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4), l4(32'hAE, 32'hAF, 32'hA0, 32'hA1), 5};
    rv = '{0, 1, 0, 32'h0, 32'h380, 1, 1,
           l4(32'h380, 32'h384, 32'h388, 32'h38C), l4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 5};

    // Reset held with a pending icache request
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_valid_done", 32'({bus.i_valid, bus.i_done, bus.d_valid, bus.d_done}), 32'd0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    chk("rst_beat_idx", 32'(bus.beat_idx), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Ack with no transaction in flight must be ignored
    stray_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack_quiet", 32'({bus.i_valid, bus.d_valid, bus.i_done, bus.d_done, bus.mem_req}), 32'd0);
      chk("stray_ack_beat", 32'(bus.beat_idx), 32'd0);
    end
    stray_ack = 1'b0;

    // Reset during a dcache read after two beats: abort without done
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h380; gap = 1;
    acks = 0;
    for (int c = 0; c < 20 && acks < 3; c++) begin
      @(negedge clk);
      if (bus.mem_ack) acks++;
      chk("abort_no_done", 32'(bus.d_done), 32'd0);
    end
    chk("abort_reached_beat2", 32'(acks), 32'd3);
    chk("abort_beat_idx", 32'(bus.beat_idx), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_d_done", 32'(bus.d_done), 32'd0);
    chk("abort_d_valid", 32'(bus.d_valid), 32'd0);
    chk("abort_beat_clr", 32'(bus.beat_idx), 32'd0);
    rst = 1'b0;
    run_vec(rv, "rereq");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port between the instruction-cache refill path and the data-cache miss/writeback path. Each cache issues a line transaction of LINE_WORDS consecutive 32-bit beats. The arbiter grants one requester at a time, sequences the beats and returns per-beat data and a completion pulse. It sits between both caches and the memory model/bus, beneath the fetch and memory pipeline stages.

Parameters:
LINE_WORDS, 4, beats per transaction (power of two, 1..16)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
i_req  input  1  icache refill request; level, held until i_done
i_addr  input  ADDR_W  icache line base address (word aligned)
i_rdata  output  DATA_W  read beat data to icache
i_valid  output  1  i_rdata valid, one cycle per beat
i_done  output  1  one-cycle pulse with the last beat
d_req  input  1  dcache request; level, held until d_done
d_we  input  1  1 = line writeback, 0 = line refill
d_addr  input  ADDR_W  dcache line base address
d_wdata  input  DATA_W  write beat data, selected by beat_idx
d_rdata  output  DATA_W  read beat data to dcache
d_valid  output  1  d_rdata valid (reads only)
d_done  output  1  one-cycle pulse with the last beat
beat_idx  output  $clog2(LINE_WORDS) (min 1)  current beat index
mem_req  output  1  memory beat request; level
mem_we  output  1  write beat
mem_addr  output  ADDR_W  beat address
mem_wdata  output  DATA_W  beat write data
mem_rdata  input  DATA_W  read data, valid with mem_ack
mem_ack  input  1  beat completion pulse; only meaningful while mem_req=1

Behaviour:
- Reset: state IDLE, beat counter 0. All outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, *_valid, *_done, *_rdata, beat_idx). A reset mid-transaction aborts it without a done pulse. Memory must tolerate mem_req dropping.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE: if d_req, go to GRANT_D; else if i_req, go to GRANT_I. Fixed priority: dcache wins. Latch the owner's base address and d_we. The grant is taken on the clock edge, so mem_req rises one cycle after the request is seen.
- GRANT_x: mem_req=1. mem_addr = base + 4*beat (ADDR_W modulo arithmetic, wraps silently). mem_we = latched d_we in GRANT_D, 0 in GRANT_I. mem_wdata = d_wdata (combinational from the current beat_idx).
- On mem_ack:
  - Read: owner's *_rdata <= mem_rdata and *_valid=1 for one cycle (registered, one cycle after ack).
  - Beat counter increments.
  - On the last beat: *_done pulses together with the final *_valid, mem_req drops, and the state returns to IDLE.
- mem_req is deasserted for exactly one cycle between transactions. IDLE arbitration happens in that cycle, so back-to-back transactions are possible.
- Requests are not resampled after grant. Dropping req mid-transaction is illegal; the transaction still completes.
- If both requesters are held continuously, dcache starves icache in the base build.
- The requester not currently granted sees *_valid=0 and *_done=0.
- mem_ack while mem_req=0 is ignored.
- Transaction latency with single-cycle memory: LINE_WORDS+1 cycles from grant to done.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. A last-owner register (reset value: icache) gives priority to the other requester when both are pending in IDLE.
- Undefined: fixed dcache priority as above. The register is absent.

Decomposition:
- Package mem_arb_pkg: enum arb_state_e {IDLE, GRANT_I, GRANT_D}, localparam BEAT_W, and owner enum for the RR register.
- One natural sub-module: mem_beat_counter, which holds the beat counter, last-beat flag and base+offset address generation.

Test Plan:
1. rst held 3 cycles with i_req=1 → mem_req=0, all outputs 0. Release → i transaction begins one cycle later.
2. i_req, i_addr=0x100, memory acks every cycle, rdata=beat+0xA0 → mem_addr 0x100,0x104,0x108,0x10C; i_valid ×4 with data A0..A3; i_done on the 4th beat.
3. i_req and d_req asserted in the same cycle, d_we=1, d_addr=0x200 → d served first with mem_we=1 and mem_wdata following beat_idx. One idle cycle, then the i transaction. With MEM_ARB_RR_EN and a prior d grant → i served first.
4. Memory acks every 3rd cycle → beats advance only on ack. Total latency 12+1 cycles. No spurious valid.
5. rst asserted after beat 2 of a d read → next cycle IDLE, mem_req=0, no d_done. Re-request completes normally.
6. Base 0xFFFFFFF8 → addresses wrap to 0x0, 0x4 on beats 3 and 4.
